// File: rtl/alu_operand_stage.sv
// alu_operand_stage: register read and operand latch in front of the 16-bit ALU.
// 8 x N register file (r0 hardwired to zero) with write-through bypass from write-back.
// Operand 2 is either a register or the immediate.
// Operands and the op code are registered one cycle after issue, with stall and flush.
module alu_operand_stage #(
   parameter int N          = 16,
   parameter int REG_ADDR_W = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_in,
   input  logic [REG_ADDR_W-1:0] rs1_addr,
   input  logic [REG_ADDR_W-1:0] rs2_addr,
   input  logic [N-1:0]          imm,
   input  logic                  use_imm,
   input  logic [2:0]            alu_ctrl_in,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  wr_en,
   input  logic [REG_ADDR_W-1:0] wr_addr,
   input  logic [N-1:0]          wr_data,
   output logic [N-1:0]          ALU_in_1,
   output logic [N-1:0]          ALU_in_2,
   output logic [2:0]            ALU_control_out,
   output logic                  valid_out
);

   localparam int NUM_REGS = 1 << REG_ADDR_W;

   // Everything the ALU sees from this stage, latched as one unit.
   typedef struct packed {
      logic [N-1:0] op1;
      logic [N-1:0] op2;
      logic [2:0]   ctrl;
   } opnd_t;

   logic [NUM_REGS-1:0][N-1:0] regs;
   logic [N-1:0]               rd1, rd2;
   opnd_t                      opnd_nxt, opnd_q;
   logic                       vld_q;

   // Register file write port.
   // Entry 0 is never written, so it stays zero from reset onward.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         regs <= '0;
      else if (wr_en && (wr_addr != '0))
         regs[wr_addr] <= wr_data;
   end

   // Read ports.
   // A same-cycle write to the addressed register is forwarded, so a
   // write-then-read hazard needs no stall.
   always_comb begin
      rd1 = '0;
      rd2 = '0;
      if (rs1_addr != '0)
         rd1 = (wr_en && (wr_addr == rs1_addr)) ? wr_data : regs[rs1_addr];
      if (rs2_addr != '0)
         rd2 = (wr_en && (wr_addr == rs2_addr)) ? wr_data : regs[rs2_addr];
   end

   // Next operand bundle.
   // A bubble (valid_in=0) loads zeros so a dead slot never carries stale data.
   always_comb begin
      opnd_nxt = '0;
      if (valid_in) begin
         opnd_nxt.op1  = rd1;
         opnd_nxt.op2  = use_imm ? imm : rd2;
         opnd_nxt.ctrl = alu_ctrl_in;
      end
   end

   // Output register: flush beats stall, and stall holds everything.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opnd_q <= '0;
         vld_q  <= 1'b0;
      end else if (flush) begin
         opnd_q <= '0;
         vld_q  <= 1'b0;
      end else if (!stall) begin
         opnd_q <= opnd_nxt;
         vld_q  <= valid_in;
      end
   end

   assign ALU_in_1        = opnd_q.op1;
   assign ALU_in_2        = opnd_q.op2;
   assign ALU_control_out = opnd_q.ctrl;
   assign valid_out       = vld_q;

endmodule
